// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one load/store request into RAM MOV/MOC handshakes,
//   doing read-modify-write for sub-word stores and aligning/extending load data.
// Latency (mem_moc on the first wait cycle): misaligned 1, load/word store 2, sub-word store 4.
// Backpressure: stalls on mem_moc_i per RAM access; req_i is dropped while busy_o or in the done cycle.
//
// Optional feature: define MAU_TIMEOUT_EN to bound every mem_moc_i wait to
// TIMEOUT_CYCLES cycles; on expiry the access is abandoned and done_o/err_o fire.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i, is_store_i, size_i,    request (sampled only in IDLE); size 00 byte,
//   unsigned_ld_i, addr_i, wdata_i  01 half, 10 word, 11 illegal
//   busy_o, done_o, err_o, rdata_o  status and extended load result
//   mem_mov_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o   RAM request side
//   mem_rdata_i, mem_moc_i        RAM response side
module mem_access_unit #(
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_ld_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic              mem_mov_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_moc_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_REL = 3'd2,
        S_WR     = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic        is_store_q,   is_store_d;
    logic [1:0]  size_q,       size_d;
    logic        uns_q,        uns_d;
    logic [1:0]  off_q,        off_d;
    logic [15:0] wdata_lo_q,   wdata_lo_d;

    // Registered outputs
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              mov_q,       mov_d;
    logic              read_q,      read_d;
    logic              write_q,     write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic accept;
    logic req_bad;
    logic wait_expired;

    assign accept = (state_q == S_IDLE) && req_i;

    // Halfwords must sit on even addresses, words on multiples of four.
    assign req_bad = (size_i == 2'b11)
                   || ((size_i == 2'b01) && addr_i[0])
                   || ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));

    // Big-endian lane extraction: byte offset 0 is the most significant byte.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the word read back from RAM.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic        is_half,
                                                input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        if (is_half) begin
            if (off[1]) r[15:0]  = wd;
            else        r[31:16] = wd;
        end else begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end
        return r;
    endfunction

`ifdef MAU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts cycles spent waiting in the current RAM access; restarts on
    // every entry into RD or WR so the write phase gets its own budget.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) && ((state_d == S_RD) || (state_d == S_WR))) begin
            wait_cnt_d = '0;
        end else if (((state_q == S_RD) || (state_q == S_WR)) && !mem_moc_i) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
    end

    assign wait_expired = (wait_cnt_q == CNT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wait_expired   = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (req_bad)                              state_d = S_FIN;
                    else if (is_store_i && (size_i == 2'b10)) state_d = S_WR;
                    else                                      state_d = S_RD;
                end
            end
            S_RD: begin
                if (mem_moc_i)         state_d = is_store_q ? S_RD_REL : S_FIN;
                else if (wait_expired) state_d = S_FIN;
            end
            // One idle cycle so MOV gets a fresh rising edge for the write.
            S_RD_REL: state_d = S_WR;
            S_WR: begin
                if (mem_moc_i || wait_expired) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (computed from next state, then registered) ----------------
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FIN);
        mov_d   = (state_d == S_RD) || (state_d == S_WR);
        read_d  = (state_d == S_RD);
        write_d = (state_d == S_WR);

        // Reaching FIN straight from IDLE means a rejected request; reaching
        // it from RD/WR without mem_moc means the wait budget ran out.
        err_d = 1'b0;
        if (state_d == S_FIN) begin
            err_d = (state_q == S_IDLE) || !mem_moc_i;
        end

        mem_addr_d = mem_addr_q;
        if (accept) begin
            mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
        end

        // mem_wdata doubles as the merge register for read-modify-write.
        mem_wdata_d = mem_wdata_q;
        if (accept && (state_d == S_WR)) begin
            mem_wdata_d = wdata_i;
        end else if ((state_q == S_RD) && mem_moc_i && is_store_q) begin
            mem_wdata_d = store_merge(mem_rdata_i, off_q, size_q[0], wdata_lo_q);
        end

        rdata_d = rdata_q;
        if ((state_q == S_RD) && mem_moc_i && !is_store_q) begin
            rdata_d = load_extend(mem_rdata_i, off_q, size_q, uns_q);
        end
    end

    // ---------------- Request capture ----------------
    always_comb begin
        is_store_d = is_store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        wdata_lo_d = wdata_lo_q;
        if (accept) begin
            is_store_d = is_store_i;
            size_d     = size_i;
            uns_d      = unsigned_ld_i;
            off_d      = addr_i[1:0];
            wdata_lo_d = wdata_i[15:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_store_q  <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_lo_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mov_q       <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_lo_q  <= wdata_lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mov_q       <= mov_d;
            read_q      <= read_d;
            write_q     <= write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_mov_o   = mov_q;
    assign mem_read_o  = read_q;
    assign mem_write_o = write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit against a word-wide RAM model with
//   programmable MOC latency, and checks results against a byte-array reference.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_mov, mem_read, mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_moc = 1'b0;

    mem_access_unit #(.ADDR_W(9), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .is_store_i(is_store),
        .size_i(size), .unsigned_ld_i(unsigned_ld), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata),
        .mem_mov_o(mem_mov), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_moc_i(mem_moc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model (word-wide, big-endian bytes) ----------------
    logic [31:0] ram [0:127];
    int ram_lat = 0;
    bit ram_stuck = 1'b0;
    int ram_wait = 0;

    always @(negedge clk) begin
        if (!mem_mov) begin
            ram_wait = 0;
            mem_moc  = 1'b0;
        end else begin
            if (!ram_stuck && ram_wait >= ram_lat) begin
                mem_moc = 1'b1;
                if (mem_read)  mem_rdata = ram[mem_addr[8:2]];
                if (mem_write) ram[mem_addr[8:2]] = mem_wdata;
            end else begin
                mem_moc = 1'b0;
            end
            ram_wait++;
        end
    end

    // ---------------- Reference model: flat byte memory ----------------
    logic [7:0] ref_mem [0:511];

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [1:0] sz, input logic uns);
        int v;
        case (sz)
            2'b00: begin
                v = int'(ref_mem[a]);
                if (!uns && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = int'(ref_mem[a]) * 256 + int'(ref_mem[a + 1]);
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = int'({ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]});
        endcase
        return v;
    endfunction

    task automatic ref_txn(input logic st, input logic [1:0] sz, input logic uns, input logic [8:0] a,
                           input logic [31:0] wd, input int lat_ram,
                           output logic bad, output int elat, output logic ld_ok, output logic [31:0] ld_val);
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        ld_ok  = 1'b0;
        ld_val = '0;
        if (bad)                      elat = 1;
        else if (st && sz != 2'b10)   elat = 4 + 2 * lat_ram;
        else                          elat = 2 + lat_ram;
        if (!bad && st) begin
            case (sz)
                2'b00: ref_mem[a] = wd[7:0];
                2'b01: begin ref_mem[a] = wd[15:8]; ref_mem[a + 1] = wd[7:0]; end
                default: for (int j = 0; j < 4; j++) ref_mem[a + j] = wd[31 - 8 * j -: 8];
            endcase
        end else if (!bad) begin
            ld_ok  = 1'b1;
            ld_val = ref_load(a, sz, uns);
        end
    endtask

    function automatic logic [31:0] ref_word(input int i);
        return {ref_mem[4 * i], ref_mem[4 * i + 1], ref_mem[4 * i + 2], ref_mem[4 * i + 3]};
    endfunction

    // ---------------- Transaction driver ----------------
    logic [2:0] trace [0:63];      // {mov, read, write} seen k cycles after req
    logic [8:0] seen_addr;

    // Called right after a falling edge; returns after one idle cycle.
    task automatic run_txn(input logic st, input logic [1:0] sz, input logic uns, input logic [8:0] a,
                           input logic [31:0] wd, input int limit,
                           output int lat, output logic e, output logic mov_seen);
        logic b1;
        req = 1'b1; is_store = st; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
        lat = -1; e = 1'b0; mov_seen = 1'b0; b1 = 1'b0;
        for (int k = 0; k < 64; k++) trace[k] = 3'b000;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) begin req = 1'b0; b1 = busy; end
            if (k < 64) trace[k] = {mem_mov, mem_read, mem_write};
            if (mem_mov) begin mov_seen = 1'b1; seen_addr = mem_addr; end
            if (done) begin
                lat = k;
                e = err;
                chk("busy_in_fin", busy, 1'b1);
                break;
            end
        end
        chk("busy_after_req", b1, 1'b1);
        @(negedge clk);
        chk("done_one_pulse", done, 1'b0);
        chk("busy_back_idle", busy, 1'b0);
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_word;   // RAM word 0x10 afterwards
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        #600000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic e, ms, bad, ld_ok, hung_bad;
        int elat;
        logic [31:0] ld_val, exp_rdata, w_before;

        vecs[0]  = '{1'b0, 2'b00, 1'b0, 9'h010, 32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h80817F01};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 9'h011, 32'h0,        32'h00000081, 1'b0, 2, 32'h80817F01};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 9'h012, 32'h0,        32'h0000007F, 1'b0, 2, 32'h80817F01};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 9'h010, 32'h0,        32'hFFFF8081, 1'b0, 2, 32'h80817F01};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 9'h010, 32'h0,        32'h00008081, 1'b0, 2, 32'h80817F01};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        32'h00007F01, 1'b0, 2, 32'h80817F01};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'h80817F01, 1'b0, 2, 32'h80817F01};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 9'h013, 32'hFFFFFFAA, 32'h80817F01, 1'b0, 4, 32'h80817FAA};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 9'h010, 32'hABCD1234, 32'h80817F01, 1'b0, 4, 32'h12347FAA};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 9'h011, 32'hFFFFFFFF, 32'h80817F01, 1'b1, 1, 32'h12347FAA};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 9'h013, 32'h0,        32'h80817F01, 1'b1, 1, 32'h12347FAA};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 9'h010, 32'h0,        32'h80817F01, 1'b1, 1, 32'h12347FAA};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 9'h013, 32'h0,        32'h000000AA, 1'b0, 2, 32'h12347FAA};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 32'h000000AA, 1'b0, 2, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 9'h011, 32'h0,        32'hFFFFFFAD, 1'b0, 2, 32'hDEADBEEF};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 9'h012, 32'h0,        32'h0000BEEF, 1'b0, 2, 32'hDEADBEEF};
        vecs[16] = '{1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 32'hDEADBEEF};

        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = (i == 4) ? 32'h80817F01 : $urandom;
            ram[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4 * i + j] = w[31 - 8 * j -: 8];
        end

        // ---- reset state ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mov", mem_mov, 1'b0);
        chk("rst_read", mem_read, 1'b0);
        chk("rst_write", mem_write, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- reset in the middle of a stalled load ----
        ram_stuck = 1'b1;
        req = 1'b1; is_store = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 9'h010;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_mov", mem_mov, 1'b1);
        chk("stall_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mov", mem_mov, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ram_stuck = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 40, lat, e, ms);
        chk("postrst_lat", lat, 2);
        chk("postrst_err", e, 1'b0);
        chk("postrst_rdata", rdata, 32'h80817F01);

        // ---- directed table ----
        ram_lat = 0;
        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, 40, lat, e, ms);
            ref_txn(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd, 0, bad, elat, ld_ok, ld_val);
            chk("vec_latency", lat, vecs[i].exp_lat);
            chk("vec_err", e, vecs[i].exp_err);
            chk("vec_rdata", rdata, vecs[i].exp_rdata);
            chk("vec_ram_word", ram[4], vecs[i].exp_word);
            chk("vec_mov_used", ms, !vecs[i].exp_err);
            if (ms) chk("vec_mem_addr", 32'(seen_addr), 32'h010);
            if (vecs[i].st && vecs[i].sz != 2'b10 && !vecs[i].exp_err) begin
                chk("rmw_cycle1_read", trace[1], 3'b110);
                chk("rmw_cycle2_release", trace[2], 3'b000);
                chk("rmw_cycle3_write", trace[3], 3'b101);
            end
        end
        exp_rdata = 32'hFFFFBEEF;

        // ---- req while busy is ignored ----
        ram_lat = 2;
        req = 1'b1; is_store = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 9'h010; wdata = '0;
        @(negedge clk);
        is_store = 1'b1; size = 2'b00; wdata = 32'h11;   // req stays high while busy
        lat = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin lat = k; req = 1'b0; break; end
        end
        req = 1'b0;
        chk("busy_req_lat", lat, 4);
        @(negedge clk);
        chk("busy_req_idle", busy, 1'b0);
        @(negedge clk);
        chk("busy_req_ram", ram[4], 32'hDEADBEEF);
        chk("busy_req_rdata", rdata, 32'hDEADBEEF);
        exp_rdata = 32'hDEADBEEF;

        // ---- req in the done cycle is ignored ----
        ram_lat = 0;
        req = 1'b1; is_store = 1'b0; size = 2'b00; addr = 9'h010;
        @(negedge clk);
        req = 1'b0;
        lat = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                req = 1'b1; is_store = 1'b1; size = 2'b00; addr = 9'h010; wdata = 32'h55;
                break;
            end
        end
        chk("fin_req_lat", lat, 2);
        @(negedge clk);
        chk("fin_req_busy", busy, 1'b0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk("fin_req_ram", ram[4], 32'hDEADBEEF);
        exp_rdata = 32'hFFFFFFDE;
        chk("fin_req_rdata", rdata, exp_rdata);

        // ---- stuck RAM ----
        ram_stuck = 1'b1;
`ifdef MAU_TIMEOUT_EN
        run_txn(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 40, lat, e, ms);
        chk("tmo_ld_lat", lat, 5);
        chk("tmo_ld_err", e, 1'b1);
        chk("tmo_ld_mov_fin", trace[5], 3'b000);
        chk("tmo_ld_mov_wait", trace[4], 3'b110);
        chk("tmo_ld_rdata", rdata, exp_rdata);
        w_before = ram[4];
        run_txn(1'b1, 2'b00, 1'b0, 9'h011, 32'h99, 40, lat, e, ms);
        chk("tmo_sb_lat", lat, 5);
        chk("tmo_sb_err", e, 1'b1);
        chk("tmo_sb_nowrite", ram[4], w_before);
        ram_stuck = 1'b0;
`else
        req = 1'b1; is_store = 1'b0; size = 2'b10; addr = 9'h010;
        hung_bad = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            if (!busy || done) hung_bad = 1'b1;
        end
        chk("wait_forever", hung_bad, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ram_stuck = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        chk("recover_rdata", rdata, exp_rdata);
`endif

        // ---- randomized traffic against the byte-array reference ----
        for (int n = 0; n < 200; n++) begin
            logic        st, uns;
            logic [1:0]  sz;
            logic [8:0]  a;
            logic [31:0] wd;
            int          l;
            st  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 9'($urandom_range(0, 511));
            wd  = $urandom;
            l   = $urandom_range(0, 2);
            ram_lat = l;
            run_txn(st, sz, uns, a, wd, 60, lat, e, ms);
            ref_txn(st, sz, uns, a, wd, l, bad, elat, ld_ok, ld_val);
            if (ld_ok) exp_rdata = ld_val;
            chk("rnd_latency", lat, elat);
            chk("rnd_err", e, bad);
            chk("rnd_rdata", rdata, exp_rdata);
            chk("rnd_mov_used", ms, !bad);
            if (ms) chk("rnd_mem_addr", 32'(seen_addr), 32'({a[8:2], 2'b00}));
        end

        for (int i = 0; i < 128; i++) begin
            chk("final_ram_word", ram[i], ref_word(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle control/datapath (MAR/MDR side) and the byte-addressed, big-endian 512x8 RAM.
- Turns one load/store request into the RAM's MOV/MOC handshake sequence.
- Supports byte, halfword and word accesses; sub-word stores are done as read-modify-write.
- Aligns load data and sign- or zero-extends it, so the control FSM only has to wait for a single done pulse.

Parameters:
ADDR_W, 9, byte address width into RAM
TIMEOUT_CYCLES, 16, max wait cycles for mem_moc per RAM access (used only with MAU_TIMEOUT_EN)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  start request; sampled only in IDLE
is_store  input  1  1=store, 0=load
size  input  2  00 byte, 01 half, 10 word, 11 illegal
unsigned_ld  input  1  1=zero-extend sub-word loads (lbu/lhu)
addr  input  ADDR_W  byte address
wdata  input  32  store data, right-justified
busy  output  1  high from cycle after accepted req through the FIN cycle
done  output  1  one-cycle completion pulse
err  output  1  valid with done; misalign/illegal size (or timeout)
rdata  output  32  extended load result; holds until next successful load
mem_mov  output  1  RAM MOV; rising edge starts an access
mem_read  output  1  RAM MemRead
mem_write  output  1  RAM MemWrite
mem_addr  output  ADDR_W  always word-aligned: {addr[ADDR_W-1:2],2'b00}
mem_wdata  output  32  RAM write data
mem_rdata  input  32  RAM read data
mem_moc  input  1  RAM completion; sampled on clock

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, err, mem_mov, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata = 0. A reset in the middle of an access drops mem_mov immediately and discards the request.
- States: IDLE, RD, RD_REL, WR, FIN. All outputs are registered.
- IDLE, req=1:
  - Latch addr, size, is_store, unsigned_ld and wdata.
  - Misalign check: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> go to FIN with err=1. No RAM access is made.
  - Word store -> WR. All other requests -> RD.
- RD: mem_mov=1, mem_read=1. On a clock edge with mem_moc=1, capture mem_rdata:
  - Load -> extract, extend and write rdata, then go to FIN.
  - Sub-word store -> merge into the captured word, then go to RD_REL.
- RD_REL: mem_mov=0, mem_read=0 for exactly one cycle, so MOV produces a fresh rising edge. Then WR.
- WR: mem_mov=1, mem_write=1, mem_wdata = merged word (or wdata for a word store). On mem_moc=1 -> FIN.
- FIN: mem_mov, mem_read, mem_write = 0; done=1; err as determined; next state IDLE.
- Lane mapping (big-endian), with o = addr[1:0]:
  - Byte at offset o occupies bits [31-8o -: 8].
  - Half at offset 0 occupies [31:16]; at offset 2 occupies [15:0].
  - Store merge replaces only the selected lane with wdata[7:0] or wdata[15:0].
- Extension: signed loads replicate the lane MSB; unsigned loads zero-fill. Word loads pass through unchanged.
- Latency, with mem_moc seen on the first cycle of each wait:
  - Load or word store: done 2 cycles after req.
  - Sub-word store: done 4 cycles after req.
  - Misaligned request: done 1 cycle after req.
- req while busy is ignored and not queued. req in the FIN cycle is also ignored.
- rdata is unchanged on stores and on errored loads.
- mem_moc outside RD/WR is ignored.

Optional Feature:
MAU_TIMEOUT_EN
- Defined: a wait counter clears on entry to RD or WR and increments each cycle without mem_moc. When it reaches TIMEOUT_CYCLES, the unit drops mem_mov/read/write and goes to FIN with err=1. A sub-word store that times out in RD performs no write.
- Not defined: the unit waits for mem_moc indefinitely and no counter exists.

Test Plan:
1. Preload word 0x10 = 0x80817F01. lb 0x10 -> rdata 0xFFFFFF80; lbu 0x11 -> 0x00000081; lb 0x12 -> 0x0000007F; each done 2 cycles after req, mem_addr 0x10.
2. Same word: lh 0x10 -> 0xFFFF8081; lhu 0x10 -> 0x00008081; lh 0x12 -> 0x00007F01; lw 0x10 -> 0x80817F01.
3. sb 0x13, wdata 0x000000AA -> sequence mov/read 1 cycle, mov=0 1 cycle, mov/write 1 cycle; RAM word becomes 0x80817FAA; done 4 cycles after req. sh 0x10, wdata 0x1234 -> word 0x12347FAA.
4. sw 0x11 and lh 0x13 -> done 1 cycle after req with err=1, mem_mov never asserted, rdata unchanged. size=11 -> same.
5. lw with mem_moc held 0 for 3 cycles; assert reset=0 mid-wait -> mem_mov, busy, done = 0 immediately. Release reset, then lw 0x10 -> 0x80817F01 normally.
6. MAU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mem_moc stuck 0 -> done+err after 4 RD cycles, mem_mov=0. Without the macro -> busy stays 1 and done stays 0 for 100 cycles.
